max_pool_vertical_buffer: RTL and testbench

- Downstream of the horizontal 2-wide max-pool array.
- Receives one beat of NUM_MODULES horizontally-pooled 2*DATA_WIDTH-bit values per handshake. Stores an even row in a line buffer. Combines it element-wise with the following odd row, completing the 2x2 max-pool.
- Emits one pooled beat per odd-row input beat, with valid/ready handshake on both sides.

---
 rtl/max_pool_vertical_buffer.sv | 101 ++++++++++
 tb/tb_max_pool_vertical_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_vertical_buffer.sv
// Vertical stage of a 2x2 max-pool: even rows go into a line buffer, odd rows
// are max'ed against it. Define MAX_POOL_VERTICAL_RELU_EN to clamp results at 0.

module max_pool_vertical_lane #(
    parameter int EW = 16
) (
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    output logic [EW-1:0] y
);
    logic [EW-1:0] m;

    always_comb begin
        m = ($signed(a) > $signed(b)) ? a : b;
`ifdef MAX_POOL_VERTICAL_RELU_EN
        y = m[EW-1] ? '0 : m;
`else
        y = m;
`endif
    end
endmodule

module max_pool_vertical_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_MODULES = 16,
    parameter int ROW_BEATS   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH*2*NUM_MODULES-1:0] data_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH*2*NUM_MODULES-1:0] data_out,
    output logic                                row_done
);
    localparam int EW = 2 * DATA_WIDTH;
    localparam int BW = EW * NUM_MODULES;
    localparam int CW = $clog2(ROW_BEATS);

    typedef enum logic {FILL, POOL} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_cnt, beat_cnt_d;
    logic [BW-1:0]   line_buf [ROW_BEATS];
    logic [BW-1:0]   rd_row, pooled;
    logic            accept, last_beat, out_load;

    assign last_beat = (beat_cnt == CW'(ROW_BEATS - 1));

    // FILL never looks at the output register, so a stalled beat can drain later
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt;
        in_ready   = (state_q == FILL) || !out_valid || out_ready;
        accept     = in_valid && in_ready;
        out_load   = accept && (state_q == POOL);
        if (accept) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt + 1'b1;
            if (last_beat)
                state_d = (state_q == FILL) ? POOL : FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            row_done  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_cnt <= beat_cnt_d;
            row_done <= out_load && last_beat;
            if (out_load) begin
                data_out  <= pooled;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line buffer content is don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (accept && state_q == FILL)
            line_buf[beat_cnt] <= data_in;
    end

    assign rd_row = line_buf[beat_cnt];

    for (genvar g = 0; g < NUM_MODULES; g++) begin : g_lane
        max_pool_vertical_lane #(.EW(EW)) u_lane (
            .a (rd_row[g*EW +: EW]),
            .b (data_in[g*EW +: EW]),
            .y (pooled[g*EW +: EW])
        );
    end
endmodule

// File: tb/tb_max_pool_vertical_buffer.sv
// Bench for max_pool_vertical_buffer: vector table, hand-written corner
// sequences and a randomized run checked against a row-level reference model.
module tb_max_pool_vertical_buffer;
    localparam int DW = 8, NM = 2, RB = 4, EW = 16, BW = 32;

    logic          clk = 0, rst = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, row_done;
    logic [BW-1:0] data_in = '0, data_out;
    int            n_tests = 0, n_fail = 0;
    int            n_acc = 0, n_out = 0, n_rd = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] even_row[RB];
    logic          rnd_on = 0;

    typedef struct {
        logic [BW-1:0] even;
        logic [BW-1:0] odd;
        logic [BW-1:0] exp;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    max_pool_vertical_buffer #(.DATA_WIDTH(DW), .NUM_MODULES(NM), .ROW_BEATS(RB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .row_done(row_done)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] pk(input int e1, input int e0);
        return {e1[15:0], e0[15:0]};
    endfunction

    function automatic logic [BW-1:0] relu_fix(input logic [BW-1:0] x);
        logic [BW-1:0] r;
        r = x;
`ifdef MAX_POOL_VERTICAL_RELU_EN
        for (int i = 0; i < NM; i++)
            if (r[i*EW+EW-1]) r[i*EW +: EW] = '0;
`endif
        return r;
    endfunction

    // Reference: element-wise signed maximum of the two row beats
    function automatic logic [BW-1:0] pool_ref(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        for (int i = 0; i < NM; i++) begin
            int x, y, m;
            x = $signed(a[i*EW +: EW]);
            y = $signed(b[i*EW +: EW]);
            m = (x > y) ? x : y;
`ifdef MAX_POOL_VERTICAL_RELU_EN
            if (m < 0) m = 0;
`endif
            r[i*EW +: EW] = m[EW-1:0];
        end
        return r;
    endfunction

    // Monitor: model follows accepted beats by row parity; outputs checked in order
    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
            exp_q.delete();
            n_acc = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
                else chk("model_out", data_out, exp_q.pop_front());
            end
            if (row_done) n_rd++;
            if (in_valid && in_ready) begin
                if (((n_acc / RB) % 2) == 0) even_row[n_acc % RB] = data_in;
                else exp_q.push_back(pool_ref(even_row[n_acc % RB], data_in));
                n_acc++;
            end
        end
    end

    // Called and returns at posedge+1; leaves in_valid high
    task automatic send(input logic [BW-1:0] d);
        int t;
        t = 0;
        in_valid = 1;
        data_in  = d;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] e[RB], o[RB];
        int rd0, out0;

        tbl[0] = '{pk(10, 5),         pk(3, 20),          pk(10, 20)};
        tbl[1] = '{pk(1, 1),          pk(1, 2),           pk(1, 2)};
        tbl[2] = '{pk(0, 0),          pk(-4, -1),         pk(0, 0)};
        tbl[3] = '{pk(7, 7),          pk(8, 6),           pk(8, 7)};
        tbl[4] = '{pk(-32768, -1),    pk(32767, -2),      pk(32767, -1)};
        tbl[5] = '{pk(-5, -3),        pk(-5, -7),         pk(-5, -3)};
        tbl[6] = '{pk(32767, 100),    pk(-32768, -100),   pk(32767, 100)};
        tbl[7] = '{pk(-1, 0),         pk(0, -1),          pk(0, 0)};

        // Reset state
        #1 rst = 1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_row_done", 32'(row_done), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table: basic pool and signed corners, full throughput
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < RB; b++) begin
                send(tbl[r*RB+b].even);
                chk("tbl_fill_no_out", 32'(out_valid), 32'd0);
            end
            for (int b = 0; b < RB; b++) begin
                send(tbl[r*RB+b].odd);
                chk("tbl_valid", 32'(out_valid), 32'd1);
                chk("tbl_data", data_out, relu_fix(tbl[r*RB+b].exp));
                chk("tbl_row_done", 32'(row_done), 32'(b == RB - 1));
            end
        end
        idle(2);

        // Backpressure after first pooled output
        for (int b = 0; b < RB; b++) begin
            e[b] = $urandom;
            o[b] = $urandom;
        end
        for (int b = 0; b < RB; b++) send(e[b]);
        send(o[0]);
        out_ready = 0;
        in_valid  = 1;
        data_in   = o[1];
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", data_out, pool_ref(e[0], o[0]));
        end
        @(posedge clk); #1;
        out_ready = 1;
        for (int b = 1; b < RB; b++) send(o[b]);
        idle(3);
        chk("bp_drain", 32'(exp_q.size()), 32'd0);

        // Back-to-back row pairs
        rd0 = n_rd; out0 = n_out;
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 2 * RB; b++) send($urandom);
        idle(3);
        chk("b2b_outputs", 32'(n_out - out0), 32'd16);
        chk("b2b_row_done", 32'(n_rd - rd0), 32'd4);
        chk("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-POOL after 2 odd beats
        for (int b = 0; b < RB + 2; b++) send($urandom);
        in_valid = 0;
        #3 rst = 1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_row_done", 32'(row_done), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        out0 = n_out;
        for (int b = 0; b < RB; b++) begin
            send($urandom);
            chk("post_rst_fill_no_out", 32'(out_valid), 32'd0);
        end
        for (int b = 0; b < RB; b++) begin
            send($urandom);
            chk("post_rst_pool_valid", 32'(out_valid), 32'd1);
        end
        idle(3);
        chk("post_rst_outputs", 32'(n_out - out0), 32'd4);
        chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

        // Randomized gaps and backpressure against the model
        rd0 = n_rd;
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int p = 0; p < 6; p++)
            for (int b = 0; b < 2 * RB; b++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send($urandom);
            end
        in_valid = 0;
        rnd_on = 0;
        repeat (2) @(posedge clk);
        #2 out_ready = 1;
        idle(5);
        chk("rnd_row_done", 32'(n_rd - rd0), 32'd6);
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
